// File: rtl/matrix_pkg.sv
// Shared constants, state type and helpers for the LED-matrix row scanner.
//   ROWS      : number of matrix rows driven through the position interface
//   CODE_W    : width of a row code (0 = no row, c = row c-1)
//   CODE_NONE : the blank row code
package matrix_pkg;

  localparam int unsigned ROWS   = 7;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Row index 0..6 maps to decoder code 1..7.
  function automatic logic [CODE_W-1:0] row_code(input int unsigned idx);
    return CODE_W'(idx + 1);
  endfunction

endpackage

// File: rtl/matrix_pair_pick.sv
// Picks the two lowest set rows of a mask and returns their codes plus the
// mask with both rows removed. Purely combinational.
//   mask   : candidate rows (bit k = row code k+1)
//   code_a : code of the lowest set row, CODE_NONE if the mask is empty
//   code_b : code of the next-lowest set row, CODE_NONE if there is none
//   rest   : mask with the chosen rows cleared
module matrix_pair_pick
  import matrix_pkg::*;
(
  input  logic [ROWS-1:0]   mask,
  output logic [CODE_W-1:0] code_a,
  output logic [CODE_W-1:0] code_b,
  output logic [ROWS-1:0]   rest
);

  logic found_a;
  logic found_b;

  // Ascending scan guarantees code_a < code_b whenever code_b is nonzero.
  always_comb begin
    code_a  = CODE_NONE;
    code_b  = CODE_NONE;
    rest    = mask;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (mask[i]) begin
        if (!found_a) begin
          code_a  = row_code(i);
          rest[i] = 1'b0;
          found_a = 1'b1;
        end else if (!found_b) begin
          code_b  = row_code(i);
          rest[i] = 1'b0;
          found_b = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_row_scanner.sv
// Time-multiplexes a 7-bit row pattern into slots of at most two row codes
// (F1/F2) for the matrix decoder, refreshing frame after frame.
//   DWELL      : cycles each slot is held (1..65535)
//   clk, rst   : clock, synchronous active-high reset
//   pattern    : requested lit rows, sampled when load=1
//   load       : single-cycle load strobe
//   F1, F2     : registered row codes of the current slot (0 = none)
//   busy       : registered, high while a nonzero pattern is being scanned
//   frame_done : registered, high on the last cycle of every frame
module matrix_row_scanner
  import matrix_pkg::*;
#(
  parameter int unsigned DWELL = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   pattern,
  input  logic              load,
  output logic [CODE_W-1:0] F1,
  output logic [CODE_W-1:0] F2,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned      CNT_W    = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_e            state_q, state_d;
  logic [ROWS-1:0]   active_q, active_d;
  logic [ROWS-1:0]   pending_q, pending_d;
  logic              pend_v_q, pend_v_d;
  logic [ROWS-1:0]   remain_q, remain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] f1_d, f2_d;
  logic              busy_d;
  logic              frame_done_d;

  logic              slot_end;
  logic [ROWS-1:0]   next_active;
  logic [ROWS-1:0]   pick_mask;
  logic [CODE_W-1:0] pick_a;
  logic [CODE_W-1:0] pick_b;
  logic [ROWS-1:0]   pick_rest;

  assign slot_end = (cnt_q == CNT_LAST);

  // Pattern for the next frame: a load on the boundary cycle beats any pending one.
  assign next_active = load ? pattern : (pend_v_q ? pending_q : active_q);

  // One picker serves the first slot of a frame and every following slot.
  always_comb begin
    pick_mask = remain_q;
    if (state_q == IDLE) begin
      pick_mask = pattern;
    end else if (remain_q == '0) begin
      pick_mask = next_active;
    end
  end

  matrix_pair_pick u_pick (
    .mask   (pick_mask),
    .code_a (pick_a),
    .code_b (pick_b),
    .rest   (pick_rest)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    remain_d  = remain_q;
    cnt_d     = cnt_q;
    f1_d      = F1;
    f2_d      = F2;

    case (state_q)
      IDLE: begin
        f1_d = CODE_NONE;
        f2_d = CODE_NONE;
        if (load && (pattern != '0)) begin
          active_d = pattern;
          f1_d     = pick_a;
          f2_d     = pick_b;
          remain_d = pick_rest;
          cnt_d    = '0;
          state_d  = HOLD;
        end
      end

      HOLD: begin
        if (load) begin
          pending_d = pattern;
          pend_v_d  = 1'b1;
        end
        if (!slot_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (remain_q != '0) begin
            f1_d     = pick_a;
            f2_d     = pick_b;
            remain_d = pick_rest;
          end else begin
            // Frame boundary: adopt the newest pattern and restart the scan.
            active_d = next_active;
            pend_v_d = 1'b0;
            if (next_active == '0) begin
              f1_d     = CODE_NONE;
              f2_d     = CODE_NONE;
              remain_d = '0;
              state_d  = IDLE;
            end else begin
              f1_d     = pick_a;
              f2_d     = pick_b;
              remain_d = pick_rest;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        f1_d    = CODE_NONE;
        f2_d    = CODE_NONE;
      end
    endcase

    busy_d = (state_d == HOLD);
    // Registered flag: raise it on the edge that enters the final dwell cycle
    // of the final slot, so it is high exactly during that cycle.
    frame_done_d = (state_d == HOLD) && (cnt_d == CNT_LAST) && (remain_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      active_q   <= '0;
      pending_q  <= '0;
      pend_v_q   <= 1'b0;
      remain_q   <= '0;
      cnt_q      <= '0;
      F1         <= CODE_NONE;
      F2         <= CODE_NONE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_v_q   <= pend_v_d;
      remain_q   <= remain_d;
      cnt_q      <= cnt_d;
      F1         <= f1_d;
      F2         <= f2_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Scoreboard bench for matrix_row_scanner: expected per-cycle outputs are
// built from the requested pattern and queued as stimulus is planned, then
// popped and compared one cycle at a time.
module tb_matrix_row_scanner;

  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [2:0] f1;
    logic [2:0] f2;
    logic       busy;
    logic       fd;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] pattern;
  logic       load;
  logic [2:0] f1, f2;
  logic       busy, frame_done;

  logic [6:0] pattern1;
  logic       load1;
  logic [2:0] f1_1, f2_1;
  logic       busy1, frame_done1;

  exp_t  sb[$];
  exp_t  sb1[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  matrix_row_scanner #(.DWELL(DW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pattern    (pattern),
    .load       (load),
    .F1         (f1),
    .F2         (f2),
    .busy       (busy),
    .frame_done (frame_done)
  );

  matrix_row_scanner #(.DWELL(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .pattern    (pattern1),
    .load       (load1),
    .F1         (f1_1),
    .F2         (f2_1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Expected outputs of one frame: rows paired in ascending order,
  // each pair held for dwell cycles; only the first ncyc cycles when ncyc >= 0.
  task automatic push_frame(input logic [6:0] p, input int ncyc, input bit fast);
    int         codes[7];
    int         n = 0;
    int         k = 0;
    int         slots;
    int         dwell;
    exp_t       e;
    dwell = fast ? 1 : int'(DW);
    for (int i = 0; i < 7; i++) if (p[i]) begin codes[n] = i + 1; n++; end
    slots = (n + 1) / 2;
    for (int s = 0; s < slots; s++) begin
      for (int d = 0; d < dwell; d++) begin
        e.f1   = 3'(codes[2*s]);
        e.f2   = (2*s + 1 < n) ? 3'(codes[2*s+1]) : 3'd0;
        e.busy = 1'b1;
        e.fd   = (s == slots - 1) && (d == dwell - 1);
        if (ncyc < 0 || k < ncyc) begin
          if (fast) sb1.push_back(e); else sb.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic push_idle(input int n, input bit fast);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      if (fast) sb1.push_back(e); else sb.push_back(e);
    end
  endtask

  // One clock: drive inputs, take the edge, compare both DUTs against their queues.
  task automatic step(input logic ld, input logic [6:0] pat);
    exp_t e;
    load    = ld;
    pattern = pat;
    @(posedge clk);
    #1;
    load  = 1'b0;
    load1 = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("F1", 32'(f1), 32'(e.f1));
      check("F2", 32'(f2), 32'(e.f2));
      check("busy", 32'(busy), 32'(e.busy));
      check("frame_done", 32'(frame_done), 32'(e.fd));
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check("F1_d1", 32'(f1_1), 32'(e.f1));
      check("F2_d1", 32'(f2_1), 32'(e.f2));
      check("busy_d1", 32'(busy1), 32'(e.busy));
      check("frame_done_d1", 32'(frame_done1), 32'(e.fd));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0);
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    pattern  = '0;
    load1    = 1'b0;
    pattern1 = '0;

    phase = "reset";
    push_idle(2, 1'b0);
    push_idle(2, 1'b1);
    run(2);
    rst = 1'b0;

    // Two rows fit one slot; the frame repeats until a zero load drains it.
    phase = "two_rows";
    push_frame(7'b0000101, -1, 1'b0);
    push_frame(7'b0000101, -1, 1'b0);
    push_frame(7'b0000101, -1, 1'b0);
    push_idle(2, 1'b0);
    step(1'b1, 7'b0000101);
    run(8);
    step(1'b1, 7'b0000000);
    run(4);

    // Full pattern, then a mid-frame load that waits for the frame to finish.
    phase = "full_then_row7";
    push_frame(7'b1111111, -1, 1'b0);
    push_frame(7'b1111111, -1, 1'b0);
    push_frame(7'b1000000, -1, 1'b0);
    push_frame(7'b1000000, -1, 1'b0);
    push_idle(2, 1'b0);
    step(1'b1, 7'b1111111);
    run(20);
    step(1'b1, 7'b1000000);
    run(15);
    step(1'b1, 7'b0000000);
    run(4);

    // Load on the frame-end cycle overrides an older pending pattern.
    phase = "boundary_load";
    push_frame(7'b0000011, -1, 1'b0);
    push_frame(7'b0001000, -1, 1'b0);
    push_frame(7'b0001000, -1, 1'b0);
    push_idle(2, 1'b0);
    step(1'b1, 7'b0000011);
    step(1'b1, 7'b0100000);
    run(2);
    step(1'b1, 7'b0001000);
    run(4);
    step(1'b1, 7'b0000000);
    run(4);

    // Two loads in one frame: the later one wins.
    phase = "last_load_wins";
    push_frame(7'b0010000, -1, 1'b0);
    push_frame(7'b0001000, -1, 1'b0);
    push_idle(2, 1'b0);
    step(1'b1, 7'b0010000);
    step(1'b1, 7'b0000011);
    step(1'b1, 7'b0001000);
    run(2);
    step(1'b1, 7'b0000000);
    run(4);

    // Reset mid-slot blanks outputs and ignores a concurrent load.
    phase = "mid_reset";
    push_frame(7'b1111111, 5, 1'b0);
    push_idle(4, 1'b0);
    step(1'b1, 7'b1111111);
    run(4);
    rst = 1'b1;
    step(1'b1, 7'b0000001);
    rst = 1'b0;
    run(3);

    // DWELL=1 single slot: frame_done every cycle; zero load ends at once.
    phase = "dwell1";
    push_frame(7'b0000010, -1, 1'b1);
    push_frame(7'b0000010, -1, 1'b1);
    push_frame(7'b0000010, -1, 1'b1);
    push_idle(2, 1'b1);
    push_idle(5, 1'b0);
    load1    = 1'b1;
    pattern1 = 7'b0000010;
    step(1'b0, 7'd0);
    run(2);
    load1    = 1'b1;
    pattern1 = 7'b0000000;
    step(1'b0, 7'd0);
    run(1);

    phase = "drain";
    check("sb_left", 32'(sb.size()), 32'd0);
    check("sb1_left", 32'(sb1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
